// File: rtl/rv_ahb_bridge_mux.sv
// AHB-Lite master bridge from the RV core load/store port to NUM_SLAVES decoded slaves,
// with pipelined address/data phases, wait states, sub-word sizes and a default ERROR slave.
`timescale 1ns/1ps
module rv_ahb_bridge_mux #(
    parameter int unsigned                   NUM_SLAVES = 2,
    parameter int unsigned                   ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE   = {32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK   = {32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_req,
    input  logic [ADDR_W-1:0]        core_addr,
    input  logic                     core_we,
    input  logic [1:0]               core_size,
    input  logic [31:0]              core_wdata,
    output logic                     core_gnt,
    output logic                     core_rvalid,
    output logic [31:0]              core_rdata,
    output logic                     core_err,
    output logic [ADDR_W-1:0]        HADDR,
    output logic [2:0]               HSIZE,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    output logic [31:0]              HWDATA,
    output logic [NUM_SLAVES-1:0]    HSEL,
    output logic                     HREADY,
    input  logic [NUM_SLAVES*32-1:0] HRDATA,
    input  logic [NUM_SLAVES-1:0]    HREADYOUT,
    input  logic [NUM_SLAVES-1:0]    HRESP
);

    localparam int unsigned IDX_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  SIZE_BYTE     = 2'b00;
    localparam logic [1:0]  SIZE_HALF     = 2'b01;
    localparam logic [1:0]  SIZE_WORD     = 2'b10;

    logic             r_dp_valid;
    logic             r_dp_we;
    logic             r_dp_def;
    logic [IDX_W-1:0] r_dp_idx;
    logic [1:0]       r_dp_lane;
    logic [1:0]       r_dp_size;
    logic [31:0]      r_dp_wdata;
    logic             r_err_state;
    logic             r_err_cut;

    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_misalign;
    logic             w_def;
    logic             w_sel_ready;
    logic             w_sel_resp;
    logic [31:0]      w_sel_rdata;
    logic             w_hready;
    logic             w_err_first;
    logic             w_err_cut;
    logic             w_resp_err;
    logic             w_gnt;
    logic [31:0]      w_shifted;
    logic [31:0]      w_rd_fmt;

    // Base/mask decode; the first matching slave in index order wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!w_hit &&
                ((core_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        case (core_size)
            SIZE_BYTE: w_misalign = 1'b0;
            SIZE_HALF: w_misalign = core_addr[0];
            SIZE_WORD: w_misalign = |core_addr[1:0];
            default:   w_misalign = 1'b1;
        endcase
    end

    assign w_def = ~w_hit | w_misalign;

    // Data-phase slave mux: ready, response and read data of the registered target.
    always_comb begin
        w_sel_ready = 1'b1;
        w_sel_resp  = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_dp_idx == IDX_W'(i)) begin
                w_sel_ready = HREADYOUT[i];
                w_sel_resp  = HRESP[i];
                w_sel_rdata = HRDATA[i*32 +: 32];
            end
        end
    end

    // Default slave answers ERROR over two cycles: not ready first, ready second.
    always_comb begin
        if (!r_dp_valid) begin
            w_hready = 1'b1;
        end else if (r_dp_def) begin
            w_hready = r_err_state;
        end else begin
            w_hready = w_sel_ready;
        end
    end

    assign w_err_first = r_dp_valid & (r_dp_def ? ~r_err_state : (w_sel_resp & ~w_sel_ready));
    assign w_err_cut   = w_err_first | r_err_cut;
    assign w_resp_err  = r_dp_def | w_sel_resp;
    assign w_gnt       = reset & core_req & w_hready & ~w_err_cut;

    assign core_gnt    = w_gnt;
    assign HREADY      = w_hready;
    assign HADDR       = core_addr;
    assign HWRITE      = core_we;
    assign HSIZE       = {1'b0, core_size};
    assign HTRANS      = w_gnt ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSEL        = (w_gnt && !w_def) ? (NUM_SLAVES'(1) << w_hit_idx) : '0;

    assign core_rvalid = r_dp_valid & w_hready;
    assign core_err    = core_rvalid & w_resp_err;

    // Right-justify the addressed lane and zero-extend to the access size.
    assign w_shifted = w_sel_rdata >> {r_dp_lane, 3'b000};

    always_comb begin
        case (r_dp_size)
            SIZE_BYTE: w_rd_fmt = {24'd0, w_shifted[7:0]};
            SIZE_HALF: w_rd_fmt = {16'd0, w_shifted[15:0]};
            default:   w_rd_fmt = w_shifted;
        endcase
    end

    assign core_rdata = (core_rvalid && !r_dp_we && !w_resp_err) ? w_rd_fmt : 32'd0;

    always_comb begin
        case (r_dp_size)
            SIZE_BYTE: HWDATA = {4{r_dp_wdata[7:0]}};
            SIZE_HALF: HWDATA = {2{r_dp_wdata[15:0]}};
            default:   HWDATA = r_dp_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dp_valid  <= 1'b0;
            r_dp_we     <= 1'b0;
            r_dp_def    <= 1'b0;
            r_dp_idx    <= '0;
            r_dp_lane   <= 2'b00;
            r_dp_size   <= 2'b00;
            r_dp_wdata  <= 32'd0;
            r_err_state <= 1'b0;
            r_err_cut   <= 1'b0;
        end else begin
            r_err_cut   <= w_err_first;
            r_err_state <= r_dp_valid & r_dp_def & ~r_err_state;
            if (w_hready) begin
                r_dp_valid <= w_gnt;
                r_dp_we    <= core_we;
                r_dp_def   <= w_def;
                r_dp_idx   <= w_hit_idx;
                r_dp_lane  <= core_addr[1:0];
                r_dp_size  <= core_size;
                r_dp_wdata <= core_wdata;
            end
        end
    end

endmodule

// File: tb/tb_rv_ahb_bridge_mux.sv
// Self-checking bench for rv_ahb_bridge_mux: directed vector table, hand sequences for
// wait/error/reset corners, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_rv_ahb_bridge_mux;

    logic        clk;
    logic        reset;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_we;
    logic [1:0]  core_size;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [1:0]  HSEL;
    logic        HREADY;
    logic [63:0] HRDATA;
    logic [1:0]  HREADYOUT;
    logic [1:0]  HRESP;

    rv_ahb_bridge_mux #(
        .NUM_SLAVES (2),
        .ADDR_W     (32),
        .SLV_BASE   ({32'h4000_0000, 32'h0000_0000}),
        .SLV_MASK   ({32'hFFFF_0000, 32'hFFFF_0000})
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_we     (core_we),
        .core_size   (core_size),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .HADDR       (HADDR),
        .HSIZE       (HSIZE),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HWDATA      (HWDATA),
        .HSEL        (HSEL),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  sel;
        logic        def;
        logic [31:0] e_rdata;
        logic [31:0] e_hwdata;
    } vec_t;

    vec_t tbl [14];

    // Random-phase model state: one pending core request, one access in flight.
    bit          rq, fl, fl_we, fl_err, cut_prev;
    bit          e_ready, e_first, e_gnt, e_rv, e_err, s_ready, s_resp;
    int          fl_tgt, fl_wait, fl_ecyc, rq_tgt, rv_cnt, err_cnt;
    logic [31:0] rq_addr, rq_wd, fl_addr, fl_wd, e_rd, e_sel;
    logic        rq_we;
    logic [1:0]  rq_size, fl_size;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic r, input logic we, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] wd);
        core_req   = r;
        core_we    = we;
        core_addr  = a;
        core_size  = sz;
        core_wdata = wd;
    endtask

    task automatic slv_idle();
        HREADYOUT = 2'b11;
        HRESP     = 2'b00;
        HRDATA    = 64'd0;
    endtask

    // Address map: slave 0 at 0x0000_xxxx, slave 1 at 0x4000_xxxx; -1 means default slave.
    function automatic int exp_target(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return -1;
        if (sz == 2'd1 && (a % 2) != 0) return -1;
        if (sz == 2'd2 && (a % 4) != 0) return -1;
        if ((a / 32'd65536) == 32'd0) return 0;
        if ((a / 32'd65536) == 32'h4000) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] w, input int lane, input logic [1:0] sz);
        logic [31:0] s;
        s = w >> (8 * lane);
        if (sz == 2'd0) return s % 32'd256;
        if (sz == 2'd1) return s % 32'd65536;
        return s;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'd0) return 32'(wd % 32'd256) * 32'h0101_0101;
        if (sz == 2'd1) return 32'(wd % 32'd65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] pat(input int idx, input logic [31:0] a);
        return 32'h5A3C_0000 ^ (32'(idx) << 28) ^ {a[15:0], ~a[15:0]};
    endfunction

    task automatic gen_req();
        int          r;
        logic [31:0] a;
        logic [1:0]  sz;
        r = int'($urandom_range(0, 4));
        case (r)
            0, 1:    a = 32'($urandom_range(0, 65535));
            2, 3:    a = 32'h4000_0000 | 32'($urandom_range(0, 65535));
            default: a = $urandom;
        endcase
        r  = int'($urandom_range(0, 9));
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            else if (sz == 2'd2) a[1:0] = 2'b00;
        end
        rq_addr = a;
        rq_size = sz;
        rq_we   = 1'($urandom_range(0, 1));
        rq_wd   = $urandom;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0010, 2'd2, 32'hDEAD_BEEF, 32'h0,         2'b01, 1'b0, 32'h0,         32'hDEAD_BEEF};
        tbl[1]  = '{1'b0, 32'h0000_0010, 2'd2, 32'h0,         32'hDEAD_BEEF, 2'b01, 1'b0, 32'hDEAD_BEEF, 32'h0};
        tbl[2]  = '{1'b0, 32'h4000_0003, 2'd0, 32'h0,         32'h1122_3344, 2'b10, 1'b0, 32'h0000_0011, 32'h0};
        tbl[3]  = '{1'b1, 32'h4000_0001, 2'd0, 32'h1234_56A5, 32'h0,         2'b10, 1'b0, 32'h0,         32'hA5A5_A5A5};
        tbl[4]  = '{1'b0, 32'h0000_0002, 2'd1, 32'h0,         32'h1122_3344, 2'b01, 1'b0, 32'h0000_1122, 32'h0};
        tbl[5]  = '{1'b1, 32'h4000_0006, 2'd1, 32'hFFFF_BEEF, 32'h0,         2'b10, 1'b0, 32'h0,         32'hBEEF_BEEF};
        tbl[6]  = '{1'b0, 32'h0000_0001, 2'd0, 32'h0,         32'h1122_3344, 2'b01, 1'b0, 32'h0000_0033, 32'h0};
        tbl[7]  = '{1'b0, 32'h8000_0000, 2'd2, 32'h0,         32'h1122_3344, 2'b00, 1'b1, 32'h0,         32'h0};
        tbl[8]  = '{1'b0, 32'h0000_0001, 2'd1, 32'h0,         32'h1122_3344, 2'b00, 1'b1, 32'h0,         32'h0};
        tbl[9]  = '{1'b1, 32'h4000_0002, 2'd2, 32'h0,         32'h0,         2'b00, 1'b1, 32'h0,         32'h0};
        tbl[10] = '{1'b0, 32'h0000_0000, 2'd3, 32'h0,         32'h1122_3344, 2'b00, 1'b1, 32'h0,         32'h0};
        tbl[11] = '{1'b0, 32'h0000_FFFE, 2'd1, 32'h0,         32'hA1B2_C3D4, 2'b01, 1'b0, 32'h0000_A1B2, 32'h0};
        tbl[12] = '{1'b0, 32'h4000_FFFF, 2'd0, 32'h0,         32'hA1B2_C3D4, 2'b10, 1'b0, 32'h0000_00A1, 32'h0};
        tbl[13] = '{1'b0, 32'h0001_0000, 2'd2, 32'h0,         32'h1122_3344, 2'b00, 1'b1, 32'h0,         32'h0};

        // Reset state, with a request asserted throughout.
        reset = 1'b0;
        set_req(1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
        HREADYOUT = 2'b01;
        HRESP     = 2'b11;
        HRDATA    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        settle();
        chk("RST.gnt",    32'(core_gnt),    32'd0);
        chk("RST.rvalid", 32'(core_rvalid), 32'd0);
        chk("RST.err",    32'(core_err),    32'd0);
        chk("RST.rdata",  core_rdata,       32'd0);
        chk("RST.htrans", 32'(HTRANS),      32'd0);
        chk("RST.hsel",   32'(HSEL),        32'd0);
        chk("RST.hready", 32'(HREADY),      32'd1);
        reset = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        slv_idle();
        tick();

        // Single zero-wait transactions from the vector table.
        for (int i = 0; i < 14; i++) begin
            tick();
            set_req(1'b1, tbl[i].we, tbl[i].addr, tbl[i].sz, tbl[i].wd);
            slv_idle();
            settle();
            chk($sformatf("T%0d.gnt", i),    32'(core_gnt), 32'd1);
            chk($sformatf("T%0d.hsel", i),   32'(HSEL),     32'(tbl[i].sel));
            chk($sformatf("T%0d.htrans", i), 32'(HTRANS),   32'd2);
            chk($sformatf("T%0d.hsize", i),  32'(HSIZE),    32'({1'b0, tbl[i].sz}));
            tick();
            set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
            HRDATA = (tbl[i].sel == 2'b10) ? {tbl[i].rd, 32'hFFFF_FFFF} : {32'hFFFF_FFFF, tbl[i].rd};
            settle();
            if (tbl[i].def) begin
                chk($sformatf("T%0d.hready_e1", i), 32'(HREADY),      32'd0);
                chk($sformatf("T%0d.rvalid_e1", i), 32'(core_rvalid), 32'd0);
                tick();
                settle();
                chk($sformatf("T%0d.hready_e2", i), 32'(HREADY),      32'd1);
            end
            chk($sformatf("T%0d.rvalid", i), 32'(core_rvalid), 32'd1);
            chk($sformatf("T%0d.err", i),    32'(core_err),    32'(tbl[i].def));
            chk($sformatf("T%0d.rdata", i),  core_rdata,       tbl[i].e_rdata);
            if (tbl[i].we && !tbl[i].def)
                chk($sformatf("T%0d.hwdata", i), HWDATA, tbl[i].e_hwdata);
        end

        // A: pipelined word write then read on slave 0.
        tick();
        set_req(1'b1, 1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF);
        slv_idle();
        settle();
        chk("A.gnt1", 32'(core_gnt), 32'd1);
        chk("A.rv1",  32'(core_rvalid), 32'd0);
        tick();
        set_req(1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
        settle();
        chk("A.gnt2",   32'(core_gnt),    32'd1);
        chk("A.hwdata", HWDATA,           32'hDEAD_BEEF);
        chk("A.rv2",    32'(core_rvalid), 32'd1);
        chk("A.err2",   32'(core_err),    32'd0);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        HRDATA = {32'h0, 32'hDEAD_BEEF};
        settle();
        chk("A.rv3",    32'(core_rvalid), 32'd1);
        chk("A.rdata3", core_rdata,       32'hDEAD_BEEF);
        chk("A.err3",   32'(core_err),    32'd0);
        tick();
        settle();
        chk("A.rv4", 32'(core_rvalid), 32'd0);

        // B: three wait states on slave 0 with a second request queued.
        tick();
        set_req(1'b1, 1'b0, 32'h20, 2'd2, 32'h0);
        slv_idle();
        settle();
        chk("B.gnt_a", 32'(core_gnt), 32'd1);
        rv_cnt = 0;
        tick();
        set_req(1'b1, 1'b0, 32'h4000_0004, 2'd2, 32'h0);
        for (int k = 0; k < 3; k++) begin
            HREADYOUT = 2'b10;
            settle();
            chk($sformatf("B.hready_w%0d", k), 32'(HREADY),   32'd0);
            chk($sformatf("B.gnt_w%0d", k),    32'(core_gnt), 32'd0);
            rv_cnt += int'(core_rvalid);
            tick();
        end
        HREADYOUT = 2'b11;
        HRDATA    = {32'h0BAD_F00D, 32'hCAFE_F00D};
        settle();
        chk("B.hready", 32'(HREADY),   32'd1);
        chk("B.rdata_a", core_rdata,   32'hCAFE_F00D);
        chk("B.gnt_b",  32'(core_gnt), 32'd1);
        chk("B.hsel_b", 32'(HSEL),     32'd2);
        rv_cnt += int'(core_rvalid);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        settle();
        chk("B.rdata_b", core_rdata, 32'h0BAD_F00D);
        rv_cnt += int'(core_rvalid);
        tick();
        settle();
        rv_cnt += int'(core_rvalid);
        chk("B.rv_count", 32'(rv_cnt), 32'd2);

        // C: unmapped read with a pipelined request held off until the error ends.
        tick();
        set_req(1'b1, 1'b0, 32'h8000_0000, 2'd2, 32'h0);
        slv_idle();
        settle();
        chk("C.gnt1",   32'(core_gnt), 32'd1);
        chk("C.hsel1",  32'(HSEL),     32'd0);
        chk("C.htrans1", 32'(HTRANS),  32'd2);
        tick();
        set_req(1'b1, 1'b0, 32'h0000_0030, 2'd2, 32'h0);
        settle();
        chk("C.hready_e1", 32'(HREADY),      32'd0);
        chk("C.gnt_e1",    32'(core_gnt),    32'd0);
        chk("C.htrans_e1", 32'(HTRANS),      32'd0);
        chk("C.rv_e1",     32'(core_rvalid), 32'd0);
        tick();
        settle();
        chk("C.hready_e2", 32'(HREADY),      32'd1);
        chk("C.rv_e2",     32'(core_rvalid), 32'd1);
        chk("C.err_e2",    32'(core_err),    32'd1);
        chk("C.rdata_e2",  core_rdata,       32'd0);
        chk("C.gnt_e2",    32'(core_gnt),    32'd0);
        chk("C.htrans_e2", 32'(HTRANS),      32'd0);
        tick();
        settle();
        chk("C.gnt3",  32'(core_gnt), 32'd1);
        chk("C.hsel3", 32'(HSEL),     32'd1);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        HRDATA = {32'h0, 32'h1357_9BDF};
        settle();
        chk("C.rv4",    32'(core_rvalid), 32'd1);
        chk("C.err4",   32'(core_err),    32'd0);
        chk("C.rdata4", core_rdata,       32'h1357_9BDF);

        // D: slave 1 signals ERROR on a write while the next request waits.
        tick();
        set_req(1'b1, 1'b1, 32'h4000_0000, 2'd2, 32'h1111_2222);
        slv_idle();
        settle();
        chk("D.gnt1", 32'(core_gnt), 32'd1);
        err_cnt = 0;
        tick();
        set_req(1'b1, 1'b0, 32'h0000_0040, 2'd2, 32'h0);
        HREADYOUT = 2'b01;
        HRESP     = 2'b10;
        settle();
        chk("D.htrans_e1", 32'(HTRANS),      32'd0);
        chk("D.gnt_e1",    32'(core_gnt),    32'd0);
        chk("D.rv_e1",     32'(core_rvalid), 32'd0);
        err_cnt += int'(core_err);
        tick();
        HREADYOUT = 2'b11;
        settle();
        chk("D.htrans_e2", 32'(HTRANS),      32'd0);
        chk("D.gnt_e2",    32'(core_gnt),    32'd0);
        chk("D.rv_e2",     32'(core_rvalid), 32'd1);
        err_cnt += int'(core_err);
        tick();
        slv_idle();
        settle();
        chk("D.gnt3",    32'(core_gnt), 32'd1);
        chk("D.htrans3", 32'(HTRANS),   32'd2);
        err_cnt += int'(core_err);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        settle();
        chk("D.rv4", 32'(core_rvalid), 32'd1);
        err_cnt += int'(core_err);
        chk("D.err_count", 32'(err_cnt), 32'd1);

        // E: reset during a waited data phase abandons it.
        tick();
        set_req(1'b1, 1'b0, 32'h50, 2'd2, 32'h0);
        slv_idle();
        settle();
        chk("E.gnt1", 32'(core_gnt), 32'd1);
        tick();
        set_req(1'b1, 1'b0, 32'h60, 2'd2, 32'h0);
        HREADYOUT = 2'b10;
        reset     = 1'b0;
        settle();
        chk("E.hready_w", 32'(HREADY), 32'd0);
        tick();
        settle();
        chk("E.htrans", 32'(HTRANS),      32'd0);
        chk("E.hsel",   32'(HSEL),        32'd0);
        chk("E.hready", 32'(HREADY),      32'd1);
        chk("E.rv",     32'(core_rvalid), 32'd0);
        chk("E.gnt",    32'(core_gnt),    32'd0);
        tick();
        reset = 1'b1;
        set_req(1'b1, 1'b0, 32'h4000_0008, 2'd2, 32'h0);
        slv_idle();
        settle();
        chk("E.gnt2",  32'(core_gnt), 32'd1);
        chk("E.hsel2", 32'(HSEL),     32'd2);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        HRDATA = {32'h2468_ACE0, 32'h0};
        settle();
        chk("E.rv3",    32'(core_rvalid), 32'd1);
        chk("E.rdata3", core_rdata,       32'h2468_ACE0);
        tick();

        // Randomized traffic against the transaction-level model.
        rq       = 1'b0;
        fl       = 1'b0;
        cut_prev = 1'b0;
        fl_tgt   = 0;
        fl_wait  = 0;
        fl_ecyc  = 0;
        fl_err   = 1'b0;
        fl_we    = 1'b0;
        fl_addr  = 32'h0;
        fl_wd    = 32'h0;
        fl_size  = 2'd0;
        tick();
        for (int c = 0; c < 3000; c++) begin
            if (!rq && $urandom_range(0, 3) != 0) begin
                gen_req();
                rq = 1'b1;
            end
            if (rq) set_req(1'b1, rq_we, rq_addr, rq_size, rq_wd);
            else    set_req(1'b0, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
            HREADYOUT = 2'($urandom_range(0, 3));
            HRESP     = 2'($urandom_range(0, 3));
            HRDATA    = {$urandom, $urandom};
            s_ready   = 1'b1;
            s_resp    = 1'b0;
            if (fl && fl_tgt >= 0) begin
                if (fl_wait > 0) begin
                    s_ready = 1'b0;
                end else if (fl_err) begin
                    s_ready = (fl_ecyc != 0);
                    s_resp  = 1'b1;
                end else begin
                    HRDATA[fl_tgt*32 +: 32] = pat(fl_tgt, fl_addr);
                end
                HREADYOUT[fl_tgt] = s_ready;
                HRESP[fl_tgt]     = s_resp;
            end
            settle();

            e_ready = !fl ? 1'b1 : (fl_tgt < 0) ? (fl_ecyc != 0) : s_ready;
            e_first = fl && ((fl_tgt < 0 && fl_ecyc == 0) ||
                             (fl_tgt >= 0 && fl_wait == 0 && fl_err && fl_ecyc == 0));
            e_gnt   = rq && e_ready && !e_first && !cut_prev;
            e_rv    = fl && e_ready;
            e_err   = e_rv && (fl_tgt < 0 || fl_err);
            e_rd    = (e_rv && !fl_we && !e_err) ? exp_rd(pat(fl_tgt, fl_addr), int'(fl_addr % 4), fl_size) : 32'd0;
            rq_tgt  = exp_target(rq_addr, rq_size);
            e_sel   = (e_gnt && rq_tgt >= 0) ? (32'd1 << rq_tgt) : 32'd0;

            chk("R.hready", 32'(HREADY),      32'(e_ready));
            chk("R.gnt",    32'(core_gnt),    32'(e_gnt));
            chk("R.rvalid", 32'(core_rvalid), 32'(e_rv));
            chk("R.err",    32'(core_err),    32'(e_err));
            chk("R.rdata",  core_rdata,       e_rd);
            chk("R.htrans", 32'(HTRANS),      e_gnt ? 32'd2 : 32'd0);
            chk("R.hsel",   32'(HSEL),        e_sel);
            chk("R.haddr",  HADDR,            core_addr);
            chk("R.hsize",  32'(HSIZE),       32'(core_size));
            if (fl && fl_we && fl_tgt >= 0)
                chk("R.hwdata", HWDATA, exp_wd(fl_wd, fl_size));

            tick();
            cut_prev = e_first;
            if (fl && !e_ready) begin
                if (fl_tgt < 0 || fl_wait == 0) fl_ecyc = 1;
                else fl_wait--;
            end else begin
                fl = e_gnt;
                if (e_gnt) begin
                    fl_tgt  = rq_tgt;
                    fl_addr = rq_addr;
                    fl_we   = rq_we;
                    fl_size = rq_size;
                    fl_wd   = rq_wd;
                    fl_wait = int'($urandom_range(0, 2));
                    fl_err  = ($urandom_range(0, 7) == 0);
                    fl_ecyc = 0;
                    rq      = 1'b0;
                end
            end
        end

        set_req(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        slv_idle();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
